// File: rtl/pipe_stage_if.sv
// Bundle of controls, upstream slot fields and registered outputs for one
// pipeline register. The master drives the stage and the slave is the register itself.
interface pipe_stage_if #(
    parameter int DW    = 32,
    parameter int TW    = 2,
    parameter int EXC_W = 5
);
    logic             stall;
    logic             flush;
    logic             int_flush;
    logic             valid_in;
    logic [31:0]      pc_in;
    logic             bd_in;
    logic [DW-1:0]    payload_in;
    logic [TW-1:0]    tnew_in;
    logic [EXC_W-1:0] exc_in;
    logic [EXC_W-1:0] exc_new;

    logic             valid_out;
    logic [31:0]      pc_out;
    logic             bd_out;
    logic [DW-1:0]    payload_out;
    logic [TW-1:0]    tnew_out;
    logic [EXC_W-1:0] exc_out;
    logic             has_exc;

    modport master (
        output stall, flush, int_flush, valid_in, pc_in, bd_in,
               payload_in, tnew_in, exc_in, exc_new,
        input  valid_out, pc_out, bd_out, payload_out, tnew_out, exc_out, has_exc
    );

    modport slave (
        input  stall, flush, int_flush, valid_in, pc_in, bd_in,
               payload_in, tnew_in, exc_in, exc_new,
        output valid_out, pc_out, bd_out, payload_out, tnew_out, exc_out, has_exc
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register. It supports stall, flush and interrupt flush.
// Tnew counts down and saturates at zero. When exception codes are merged, the oldest one wins.
module pipe_stage_reg #(
    parameter int          DW           = 32,
    parameter int          TW           = 2,
    parameter int          EXC_W        = 5,
    parameter logic [31:0] RESET_PC     = 32'h3000,
    parameter logic [31:0] HANDLER_PC   = 32'h4180,
    parameter bit          DEC_ON_STALL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    pipe_stage_if.slave  bus
);

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // The earlier stage's code takes precedence. A bubble never carries an exception.
    logic [EXC_W-1:0] exc_merged;
    always_comb begin
        exc_merged = '0;
        if (bus.valid_in)
            exc_merged = (bus.exc_in != '0) ? bus.exc_in : bus.exc_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid_out   <= 1'b0;
            bus.pc_out      <= RESET_PC;
            bus.bd_out      <= 1'b0;
            bus.payload_out <= '0;
            bus.tnew_out    <= '0;
            bus.exc_out     <= '0;
        end else if (bus.int_flush) begin
            bus.valid_out   <= 1'b0;
            bus.pc_out      <= HANDLER_PC;
            bus.bd_out      <= 1'b0;
            bus.payload_out <= '0;
            bus.tnew_out    <= '0;
            bus.exc_out     <= '0;
        end else if (bus.flush) begin
            // The bubble keeps the incoming PC and bd flag, so EPC stays correct
            // when an interrupt lands on it.
            bus.valid_out   <= 1'b0;
            bus.pc_out      <= bus.pc_in;
            bus.bd_out      <= bus.bd_in;
            bus.payload_out <= '0;
            bus.tnew_out    <= '0;
            bus.exc_out     <= '0;
        end else if (bus.stall) begin
            if (DEC_ON_STALL)
                bus.tnew_out <= sat_dec(bus.tnew_out);
        end else begin
            bus.valid_out   <= bus.valid_in;
            bus.pc_out      <= bus.pc_in;
            bus.bd_out      <= bus.bd_in;
            bus.payload_out <= bus.payload_in;
            bus.tnew_out    <= sat_dec(bus.tnew_in);
            bus.exc_out     <= exc_merged;
        end
    end

    assign bus.has_exc = bus.valid_out && (bus.exc_out != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed test of pipe_stage_reg. Instance a uses the defaults.
// Instance b uses a 3-bit Tnew and counts Tnew down while stalled.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipe_stage_if                a ();
    pipe_stage_if #(.TW(3))      b ();

    pipe_stage_reg ua (.clk(clk), .reset(reset), .bus(a));
    pipe_stage_reg #(.TW(3), .DEC_ON_STALL(1'b1)) ub (.clk(clk), .reset(reset), .bus(b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        a.stall = 0; a.flush = 0; a.int_flush = 0; a.valid_in = 0;
        a.pc_in = '0; a.bd_in = 0; a.payload_in = '0; a.tnew_in = '0;
        a.exc_in = '0; a.exc_new = '0;
    endtask

    task automatic idle_b();
        b.stall = 0; b.flush = 0; b.int_flush = 0; b.valid_in = 0;
        b.pc_in = '0; b.bd_in = 0; b.payload_in = '0; b.tnew_in = '0;
        b.exc_in = '0; b.exc_new = '0;
    endtask

    initial begin
        idle_a();
        idle_b();
        reset = 1;
        step();
        step();
        check("rst_valid",   a.valid_out,   0);
        check("rst_pc",      a.pc_out,      32'h3000);
        check("rst_bd",      a.bd_out,      0);
        check("rst_payload", a.payload_out, 0);
        check("rst_tnew",    a.tnew_out,    0);
        check("rst_exc",     a.exc_out,     0);
        check("rst_has_exc", a.has_exc,     0);
        reset = 0;

        // Test 1: a plain load
        a.valid_in = 1; a.pc_in = 32'h3004; a.tnew_in = 2;
        a.payload_in = 32'hA5A5A5A5; a.bd_in = 0;
        step();
        check("ld_valid",   a.valid_out,   1);
        check("ld_pc",      a.pc_out,      32'h3004);
        check("ld_tnew",    a.tnew_out,    1);
        check("ld_payload", a.payload_out, 32'hA5A5A5A5);
        check("ld_has_exc", a.has_exc,     0);

        // A load with tnew_in = 0 saturates at zero
        a.tnew_in = 0; a.pc_in = 32'h3008;
        step();
        check("sat_tnew", a.tnew_out, 0);

        // With DEC_ON_STALL = 0, a stall holds every output, including Tnew
        a.tnew_in = 3; a.pc_in = 32'h300C; a.bd_in = 1; a.payload_in = 32'h11112222;
        step();
        check("ld3_tnew", a.tnew_out, 2);
        a.stall = 1; a.pc_in = 32'h3FFC; a.bd_in = 0; a.payload_in = 32'h0; a.tnew_in = 0;
        a.valid_in = 0;
        step();
        step();
        check("hold_pc",      a.pc_out,      32'h300C);
        check("hold_tnew",    a.tnew_out,    2);
        check("hold_bd",      a.bd_out,      1);
        check("hold_payload", a.payload_out, 32'h11112222);
        check("hold_valid",   a.valid_out,   1);
        a.stall = 0;

        // Test 3: exception merge
        a.valid_in = 1; a.pc_in = 32'h3010; a.bd_in = 0;
        a.exc_in = 4; a.exc_new = 12;
        step();
        check("exc_old",     a.exc_out, 4);
        check("exc_old_has", a.has_exc, 1);
        a.exc_in = 0;
        step();
        check("exc_new", a.exc_out, 12);
        a.valid_in = 0;
        step();
        check("exc_bubble",     a.exc_out, 0);
        check("exc_bubble_has", a.has_exc, 0);

        // Test 4: when flush and stall are both asserted, flush wins
        a.valid_in = 1; a.exc_in = 0; a.exc_new = 0; a.payload_in = 32'h5A5A0001; a.tnew_in = 3;
        step();
        a.stall = 1; a.flush = 1; a.pc_in = 32'h3010; a.bd_in = 1;
        a.payload_in = 32'h123; a.exc_new = 5;
        step();
        check("fl_valid",   a.valid_out,   0);
        check("fl_pc",      a.pc_out,      32'h3010);
        check("fl_bd",      a.bd_out,      1);
        check("fl_payload", a.payload_out, 0);
        check("fl_tnew",    a.tnew_out,    0);
        check("fl_exc",     a.exc_out,     0);

        // Test 5: int_flush beats flush and stall
        a.int_flush = 1;
        step();
        check("if_pc",    a.pc_out,    32'h4180);
        check("if_bd",    a.bd_out,    0);
        check("if_valid", a.valid_out, 0);

        // Load a full slot, then assert reset while the stage is stalled
        a.int_flush = 0; a.flush = 0; a.stall = 0;
        a.valid_in = 1; a.pc_in = 32'h3020; a.bd_in = 1; a.payload_in = 32'hFF;
        a.tnew_in = 3; a.exc_in = 7; a.exc_new = 0;
        step();
        check("pre_rst_has_exc", a.has_exc, 1);
        a.stall = 1; reset = 1;
        step();
        check("rs_pc",      a.pc_out,      32'h3000);
        check("rs_valid",   a.valid_out,   0);
        check("rs_bd",      a.bd_out,      0);
        check("rs_payload", a.payload_out, 0);
        check("rs_tnew",    a.tnew_out,    0);
        check("rs_exc",     a.exc_out,     0);
        reset = 0;
        idle_a();

        // Test 2 (second part): with DEC_ON_STALL = 1, Tnew counts down to 0 while stalled
        b.valid_in = 1; b.pc_in = 32'h3100; b.tnew_in = 4; b.payload_in = 32'hCAFE;
        step();
        check("b_ld_tnew", b.tnew_out, 3);
        b.stall = 1; b.tnew_in = 7; b.pc_in = 32'h3104;
        step();
        check("b_st1_tnew", b.tnew_out, 2);
        step();
        check("b_st2_tnew", b.tnew_out, 1);
        step();
        check("b_st3_tnew", b.tnew_out, 0);
        step();
        check("b_st4_tnew", b.tnew_out, 0);
        check("b_st_pc",    b.pc_out,   32'h3100);
        check("b_st_payload", b.payload_out, 32'hCAFE);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
